load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Initiator side of the word-addressed data memory interface (address, write_data, mem_write, mem_read, read_data).
- Accepts byte, halfword and word load/store requests from the core over a valid/ready handshake.
- Drives word-aligned accesses to the data memory, which has a registered write and a combinational read.
- Performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Returns one registered response per request.

Parameters:
- ADDR_W, 32, address width of core request and memory address.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend sub-word loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  DATA_W  load result; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal-size request.
- mem_address  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2],2'b00}.
- mem_write_data  out  DATA_W  merged store word.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_read_data  in  DATA_W  combinational memory read data.

Behaviour:
- Single clock domain. Reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_error=0; resp_rdata=0; mem_write=0; mem_read=0; mem_address=0; mem_write_data=0; all latched request fields 0.
- States:
  - IDLE: req_ready=1. Accept on the clock edge where req_valid=1, latching addr, size, write, unsigned and wdata. Transitions:
    - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with error=1.
    - Load -> LOAD.
    - Word store -> STORE.
    - Byte/half store -> RMW_RD.
  - LOAD: mem_read=1. Sample mem_read_data at the edge, extract the lane, extend, register into resp_rdata -> RESP.
  - RMW_RD: mem_read=1. Sample mem_read_data and merge req_wdata into the addressed lane(s) into the merge register -> STORE.
  - STORE: mem_write=1; mem_write_data = merge register (word store: latched wdata). Memory updates at the edge -> RESP.
  - RESP: resp_valid=1 for exactly one cycle; req_ready=0 -> IDLE. No response backpressure.
- mem_read, mem_write and req_ready decode from the state register. They are never asserted together, and mem_read/mem_write are 0 outside their states.
- Lanes are little-endian: byte k = bits [8k+7:8k] with k=addr[1:0]; half at addr[1]=h = bits [16h+15:16h].
- Extension:
  - Signed sub-word load: sign-extend from bit 7/15.
  - req_unsigned=1: zero-extend.
  - req_unsigned is ignored for word loads.
- Stores use req_wdata[7:0] for bytes and req_wdata[15:0] for halves; upper bits are ignored.
- Latency, measured in cycles after the accept edge, to resp_valid:
  - Error: 1.
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
- Busy behaviour: req_ready=0 in every non-IDLE state. A held req_valid is accepted on the first IDLE edge. RESP->IDLE costs one cycle, so the next accept is no earlier than the cycle after resp_valid.
- Reset mid-operation: state returns to IDLE immediately and mem_write drops asynchronously. If reset hits during RMW_RD, memory is never written. The latched request is discarded and no response is issued.
- Error responses perform no memory access. resp_rdata=0 with resp_error=1.

Optional Feature:
- LSU_PERF_CNT_EN defined: adds outputs cnt_loads, cnt_stores, cnt_errors, each 32 bits.
  - Each increments by one on the edge leaving RESP, according to the completed request type; errors count only in cnt_errors.
  - Counters wrap 0xFFFFFFFF->0 and reset to 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 -> mem word[4]=0xDEADBEEF; load resp_rdata=0xDEADBEEF 2 cycles after accept; resp_error=0.
- Preload word[4]=0x11223344, store byte 0xAA @0x11 -> mem_read high 1 cycle, then mem_write high 1 cycle with data 0x1122AA44; resp_valid 3 cycles after accept.
- With word[4]=0x1122AA44, do three loads:
  - Signed byte load @0x11 -> 0xFFFFFFAA.
  - Unsigned byte load @0x11 -> 0x000000AA.
  - Signed half load @0x12 -> 0x00001122.
- Half load @0x13 and size=11 @0x10 -> resp_error=1, resp_rdata=0 one cycle after accept; mem_read/mem_write stay 0.
- Pull rst_n low during RMW_RD of a byte store to 0x10 -> mem_write never asserted, word[4] unchanged, req_ready=1 and no resp_valid after release.
- Hold req_valid high for two back-to-back word loads -> req_ready low while busy; second accept on the cycle after the first resp_valid. With LSU_PERF_CNT_EN, cnt_loads=2.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory signals of the load/store unit.
// master: the load/store unit; slave: the core plus data memory around it.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_write, mem_read
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit driving a word-addressed memory (registered write, comb read).
// Optional LSU_PERF_CNT_EN adds load/store/error completion counters.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.master bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       cnt_loads,
  output logic [31:0]       cnt_stores,
  output logic [31:0]       cnt_errors
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [1:0]  SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    STORE  = 3'd3,
    RESP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_error_q, resp_error_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [1:0]        off_q, off_d;

  logic              req_err;
  logic [4:0]        byte_sh, half_sh;
  logic [DATA_W-1:0] byte_lane, half_lane, load_ext, lane_mask, lane_ins, rmw_word;

`ifdef LSU_PERF_CNT_EN
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_loads_q, cnt_loads_d;
  logic [31:0]       cnt_stores_q, cnt_stores_d;
  logic [31:0]       cnt_errors_q, cnt_errors_d;
`endif

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    byte_sh   = {off_q, 3'b000};
    half_sh   = {off_q[1], 4'b0000};
    byte_lane = bus.mem_read_data >> byte_sh;
    half_lane = bus.mem_read_data >> half_sh;
    load_ext  = bus.mem_read_data;
    case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? DATA_W'(byte_lane[BYTE_W-1:0])
                        : {{(DATA_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane[BYTE_W-1:0]};
      SZ_HALF: load_ext = unsigned_q ? DATA_W'(half_lane[HALF_W-1:0])
                        : {{(DATA_W-HALF_W){half_lane[HALF_W-1]}}, half_lane[HALF_W-1:0]};
      default: load_ext = bus.mem_read_data;
    endcase
    if (size_q == SZ_BYTE) begin
      lane_mask = DATA_W'(8'hFF) << byte_sh;
      lane_ins  = DATA_W'(merge_q[BYTE_W-1:0]) << byte_sh;
    end else begin
      lane_mask = DATA_W'(16'hFFFF) << half_sh;
      lane_ins  = DATA_W'(merge_q[HALF_W-1:0]) << half_sh;
    end
    rmw_word = (bus.mem_read_data & ~lane_mask) | lane_ins;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    resp_error_d  = resp_error_q;
    resp_rdata_d  = resp_rdata_q;
    mem_address_d = mem_address_q;
    merge_d       = merge_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    off_d         = off_q;
`ifdef LSU_PERF_CNT_EN
    write_d       = write_q;
    err_d         = err_q;
    cnt_loads_d   = cnt_loads_q;
    cnt_stores_d  = cnt_stores_q;
    cnt_errors_d  = cnt_errors_q;
`endif
    req_err = (bus.req_size == SZ_ILL)
            | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
            | ((bus.req_size == SZ_WORD) & (bus.req_addr[1:0] != 2'b00));

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_d        = bus.req_size;
          unsigned_d    = bus.req_unsigned;
          off_d         = bus.req_addr[1:0];
          merge_d       = bus.req_wdata;
          mem_address_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
          resp_rdata_d  = '0;
          resp_error_d  = req_err;
`ifdef LSU_PERF_CNT_EN
          write_d       = bus.req_write;
          err_d         = req_err;
`endif
          if (req_err)                       state_d = RESP;
          else if (!bus.req_write)           state_d = LOAD;
          else if (bus.req_size == SZ_WORD)  state_d = STORE;
          else                               state_d = RMW_RD;
        end
      end
      LOAD: begin
        resp_rdata_d = load_ext;
        state_d      = RESP;
      end
      RMW_RD: begin
        merge_d = rmw_word;
        state_d = STORE;
      end
      STORE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
`ifdef LSU_PERF_CNT_EN
        if (err_q)        cnt_errors_d = cnt_errors_q + 32'd1;
        else if (write_q) cnt_stores_d = cnt_stores_q + 32'd1;
        else              cnt_loads_d  = cnt_loads_q + 32'd1;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Control outputs are flopped versions of the upcoming state decode
    req_ready_d  = (state_d == IDLE);
    mem_read_d   = (state_d == LOAD) || (state_d == RMW_RD);
    mem_write_d  = (state_d == STORE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      merge_q       <= '0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      off_q         <= '0;
`ifdef LSU_PERF_CNT_EN
      write_q       <= 1'b0;
      err_q         <= 1'b0;
      cnt_loads_q   <= '0;
      cnt_stores_q  <= '0;
      cnt_errors_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      merge_q       <= merge_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      off_q         <= off_d;
`ifdef LSU_PERF_CNT_EN
      write_q       <= write_d;
      err_q         <= err_d;
      cnt_loads_q   <= cnt_loads_d;
      cnt_stores_q  <= cnt_stores_d;
      cnt_errors_q  <= cnt_errors_d;
`endif
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = merge_q;
`ifdef LSU_PERF_CNT_EN
  assign cnt_loads  = cnt_loads_q;
  assign cnt_stores = cnt_stores_q;
  assign cnt_errors = cnt_errors_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, 16-word data memory.
module tb_load_store_unit;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef LSU_PERF_CNT_EN
  logic [31:0] cnt_loads, cnt_stores, cnt_errors;
`endif

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LSU_PERF_CNT_EN
    ,
    .cnt_loads  (cnt_loads),
    .cnt_stores (cnt_stores),
    .cnt_errors (cnt_errors)
`endif
  );

  // Data memory: combinational read, registered write
  logic [31:0] dmem [16];
  assign bus.mem_read_data = dmem[bus.mem_address[5:2]];
  always @(posedge clk) if (bus.mem_write) dmem[bus.mem_address[5:2]] <= bus.mem_write_data;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wword;
    logic [31:0] maddr;
  } exp_t;

  logic [7:0] rmem [64];
  exp_t exp_q [$];
  int   acc_q [$];
  int   total = 0, bad = 0, cyc = 0, pending = 0, rd_cnt = 0, wr_cnt = 0, last_resp = -100;
  int   exp_loads = 0, exp_stores = 0, exp_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w |= 32'(rmem[idx*4+i]) << (8*i);
    return w;
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    dmem[idx] = v;
    for (int i = 0; i < 4; i++) rmem[idx*4+i] = v[8*i +: 8];
  endtask

  // Reference: memory as a byte array, little-endian, extension from the access width
  function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [5:0] a, input logic [31:0] wd);
    exp_t e;
    int n;
    logic [31:0] v;
    e.rdata = '0; e.err = '0; e.lat = 1; e.nrd = 0; e.nwr = 0; e.wword = '0;
    e.maddr = {26'd0, a[5:2], 2'b00};
    if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) begin
      e.err = 32'd1;
      return e;
    end
    n = 1 << sz;
    if (!wr) begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 32'(rmem[int'(a)+i]) << (8*i);
      if (n < 4 && !uns && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
      e.rdata = v; e.lat = 2; e.nrd = 1;
    end else begin
      for (int i = 0; i < n; i++) rmem[int'(a)+i] = wd[8*i +: 8];
      e.wword = ref_word(int'(a[5:2]));
      e.lat = (n == 4) ? 2 : 3;
      e.nrd = (n == 4) ? 0 : 1;
      e.nwr = 1;
    end
    return e;
  endfunction

  // Drive one request starting just after a rising edge; acc = edge index of acceptance
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns, input logic [5:0] a,
                        input logic [31:0] wd, input bit commit, input bit keep, output int acc);
    exp_t e;
    bus.req_write = wr; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = {26'd0, a}; bus.req_wdata = wd; bus.req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin acc = cyc + 1; break; end
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready stayed 0, required 1 within 20 cycles");
      bus.req_valid = 1'b0;
      return;
    end
    if (commit) begin
      e = model(wr, sz, uns, a, wd);
      exp_q.push_back(e);
      if (e.err != 0) exp_errors++; else if (wr) exp_stores++; else exp_loads++;
    end
    @(posedge clk); #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pending == 0 && exp_q.size() == 0) break;
    end
    if (pending != 0 || exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL idle_timeout: pending=%0d queued=%0d, required 0", pending, exp_q.size());
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Monitor: protocol checks and scoreboard pops
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); acc_q.delete();
      pending = 0; rd_cnt = 0; wr_cnt = 0;
    end else begin
      check("rd_wr_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
      if (pending > 0) check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
      if (bus.mem_read) begin
        rd_cnt++;
        if (exp_q.size() > 0) check("rd_addr", bus.mem_address, exp_q[0].maddr);
      end
      if (bus.mem_write) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: mem_write=1, required 0");
        end else begin
          check("wr_addr", bus.mem_address, exp_q[0].maddr);
          check("wr_data", bus.mem_write_data, exp_q[0].wword);
        end
      end
      if (bus.resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: resp_valid=1, required 0");
        end else begin
          exp_t e;
          int acc;
          e = exp_q.pop_front();
          acc = acc_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_error", {31'd0, bus.resp_error}, e.err);
          check("latency", 32'(cyc - acc + 1), 32'(e.lat));
          check("mem_reads", 32'(rd_cnt), 32'(e.nrd));
          check("mem_writes", 32'(wr_cnt), 32'(e.nwr));
        end
        rd_cnt = 0; wr_cnt = 0;
        if (pending > 0) pending--;
        last_resp = cyc;
      end
      if (bus.req_valid && bus.req_ready) begin
        pending++;
        acc_q.push_back(cyc + 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 16; i++) preload(i, $urandom);

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_mem_addr", bus.mem_address, 32'd0);
    check("rst_mem_wdata", bus.mem_write_data, 32'd0);
`ifdef LSU_PERF_CNT_EN
    check("rst_cnt", cnt_loads | cnt_stores | cnt_errors, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then word load
    do_req(1'b1, 2'd2, 1'b0, 6'h10, 32'hDEADBEEF, 1'b1, 1'b0, a1);
    do_req(1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 1'b1, 1'b0, a1);
    wait_idle();
    check("word_store_mem", dmem[4], 32'hDEADBEEF);

    // Byte store read-modify-write
    preload(4, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 6'h11, 32'h123456AA, 1'b1, 1'b0, a1);
    wait_idle();
    check("byte_store_mem", dmem[4], 32'h1122AA44);

    // Sub-word loads and errors
    do_req(1'b0, 2'd0, 1'b0, 6'h11, 32'h0, 1'b1, 1'b0, a1);
    do_req(1'b0, 2'd0, 1'b1, 6'h11, 32'h0, 1'b1, 1'b0, a1);
    do_req(1'b0, 2'd1, 1'b0, 6'h12, 32'h0, 1'b1, 1'b0, a1);
    do_req(1'b0, 2'd1, 1'b0, 6'h13, 32'h0, 1'b1, 1'b0, a1);
    do_req(1'b0, 2'd3, 1'b0, 6'h10, 32'h0, 1'b1, 1'b0, a1);
    do_req(1'b1, 2'd2, 1'b0, 6'h12, 32'hCAFEF00D, 1'b1, 1'b0, a1);
    wait_idle();

    // Reset during RMW_RD of a byte store: nothing written, no response
    do_req(1'b1, 2'd0, 1'b0, 6'h10, 32'h00000055, 1'b0, 1'b0, a1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.mem_read) break;
    end
    check("rmw_read_seen", {31'd0, bus.mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    exp_loads = 0; exp_stores = 0; exp_errors = 0;
    #1 check("rst_mid_write", {31'd0, bus.mem_write}, 32'd0);
    check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
      check("post_rst_resp", {31'd0, bus.resp_valid}, 32'd0);
      check("post_rst_write", {31'd0, bus.mem_write}, 32'd0);
    end
    check("rst_mid_mem", dmem[4], ref_word(4));
    @(posedge clk); #1;

    // Two back-to-back word loads with req_valid held
    do_req(1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 1'b1, 1'b1, a1);
    do_req(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, 1'b1, 1'b0, a2);
    check("b2b_accept", 32'(a2), 32'(last_resp + 2));
    wait_idle();
`ifdef LSU_PERF_CNT_EN
    check("cnt_loads_b2b", cnt_loads, 32'(exp_loads));
`endif

    // Randomized traffic, occasionally holding req_valid back-to-back
    for (int n = 0; n < 300; n++) begin
      logic       wr;
      logic [1:0] sz;
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(wr, sz, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
             1'b1, 1'($urandom_range(0, 1)), a1);
    end
    bus.req_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 16; i++) check("final_mem", dmem[i], ref_word(i));
`ifdef LSU_PERF_CNT_EN
    check("cnt_loads", cnt_loads, 32'(exp_loads));
    check("cnt_stores", cnt_stores, 32'(exp_stores));
    check("cnt_errors", cnt_errors, 32'(exp_errors));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
